// File: rtl/riot_timer_bank.sv
// riot_timer_bank: CHANNELS independent 6532-style interval timers behind one
// CPU register window, with auto-reload, per-channel prescaler select, CE
// gating and a combined active-low IRQ.
// Optional feature macro: RIOT_TIMER_CASCADE_EN (cascade channel n from the
// expiries of channel n-1 when CAS=1).
module riot_timer_bank #(
    parameter int CHANNELS = 4,
    parameter int TIMER_W  = 8,
    parameter int ADDR_W   = 4,
    parameter int PS0      = 1,
    parameter int PS1      = 8,
    parameter int PS2      = 64,
    parameter int PS3      = 1024
) (
    input  logic               CLK,
    input  logic               RES,
    input  logic               CE,
    input  logic               CS,
    input  logic               R_W_n,
    input  logic [ADDR_W-1:0]  A,
    input  logic [TIMER_W-1:0] Din,
    output logic [TIMER_W-1:0] Dout,
    output logic               IRQ_n
);

    localparam int PS_W = 16;
    localparam int CH_W = ADDR_W - 2;

    typedef logic [PS_W-1:0] ps_t;

    logic [TIMER_W-1:0] count_q  [CHANNELS];
    logic [TIMER_W-1:0] count_d  [CHANNELS];
    logic [TIMER_W-1:0] reload_q [CHANNELS];
    logic [TIMER_W-1:0] reload_d [CHANNELS];
    ps_t                ps_q     [CHANNELS];
    ps_t                ps_d     [CHANNELS];
    logic [1:0]         sel_q    [CHANNELS];
    logic [1:0]         sel_d    [CHANNELS];
    logic [CHANNELS-1:0] ie_q, ie_d;
    logic [CHANNELS-1:0] ar_q, ar_d;
    logic [CHANNELS-1:0] flag_q, flag_d;
    logic [CHANNELS-1:0] exp_q, exp_d;
    logic [CHANNELS-1:0] run_q, run_d;
`ifdef RIOT_TIMER_CASCADE_EN
    logic [CHANNELS-1:0] cas_q, cas_d;
`endif

    logic [TIMER_W-1:0] dout_q;
    logic [TIMER_W-1:0] rdData;

    logic [CH_W-1:0] chanIdx;
    logic [1:0]      regSel;
    logic            wrEn;
    logic            rdEn;

    assign chanIdx = A[ADDR_W-1:2];
    assign regSel  = A[1:0];
    assign wrEn    = CS & ~R_W_n;
    assign rdEn    = CS & R_W_n;

    // Prescaler reload value (divide - 1) for a select code.
    function automatic ps_t psLoad(input logic [1:0] sel);
        case (sel)
            2'd0:    return ps_t'(PS0 - 1);
            2'd1:    return ps_t'(PS1 - 1);
            2'd2:    return ps_t'(PS2 - 1);
            default: return ps_t'(PS3 - 1);
        endcase
    endfunction

    // Per-channel next state: clears first, then the timer step (so a set
    // beats a clear), then register writes (so a COUNT write beats a step).
    always_comb begin : nextState
        logic expirePrev;
        logic thisExpire;
        logic stepFire;
        logic casMode;
        logic hit;
        logic countWr;
        expirePrev = 1'b0;
        thisExpire = 1'b0;
        stepFire   = 1'b0;
        casMode    = 1'b0;
        hit        = 1'b0;
        countWr    = 1'b0;
        ie_d       = ie_q;
        ar_d       = ar_q;
        flag_d     = flag_q;
        exp_d      = exp_q;
        run_d      = run_q;
`ifdef RIOT_TIMER_CASCADE_EN
        cas_d      = cas_q;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            count_d[i]  = count_q[i];
            reload_d[i] = reload_q[i];
            ps_d[i]     = ps_q[i];
            sel_d[i]    = sel_q[i];
            hit         = (int'(chanIdx) == i);
            countWr     = wrEn && hit && (regSel == 2'd0);
            stepFire    = 1'b0;
`ifdef RIOT_TIMER_CASCADE_EN
            casMode     = (i != 0) && cas_q[i];
`else
            casMode     = 1'b0;
`endif
            if (casMode) begin
                stepFire = run_q[i] & expirePrev;
            end else if (CE && run_q[i]) begin
                if (exp_q[i] || (ps_q[i] == '0)) begin
                    stepFire = 1'b1;
                end else begin
                    ps_d[i] = ps_q[i] - PS_W'(1);
                end
            end

            if (rdEn && hit && (regSel == 2'd0)) begin
                flag_d[i] = 1'b0;
            end
            if (wrEn && hit && (regSel == 2'd3) && Din[0]) begin
                flag_d[i] = 1'b0;
            end

            if (stepFire) begin
                if (count_q[i] != '0) begin
                    count_d[i] = count_q[i] - TIMER_W'(1);
                    ps_d[i]    = psLoad(sel_q[i]);
                end else if (ar_q[i]) begin
                    count_d[i] = reload_q[i];
                    ps_d[i]    = psLoad(sel_q[i]);
                    flag_d[i]  = 1'b1;
                end else begin
                    count_d[i] = '1;
                    exp_d[i]   = 1'b1;
                    flag_d[i]  = 1'b1;
                end
            end
            thisExpire = stepFire && (count_q[i] == '0) && !countWr;

            if (wrEn && hit) begin
                case (regSel)
                    2'd0: begin
                        count_d[i] = Din;
                        ps_d[i]    = psLoad(sel_q[i]);
                        flag_d[i]  = 1'b0;
                        exp_d[i]   = 1'b0;
                        run_d[i]   = 1'b1;
                    end
                    2'd1: begin
                        sel_d[i] = Din[1:0];
                        ie_d[i]  = Din[2];
                        ar_d[i]  = Din[3];
`ifdef RIOT_TIMER_CASCADE_EN
                        cas_d[i] = Din[4];
`endif
                    end
                    2'd2: reload_d[i] = Din;
                    default: begin
                        if (!Din[2]) begin
                            run_d[i] = 1'b0;
                        end
                    end
                endcase
            end
            expirePrev = thisExpire;
        end
    end

    // Read multiplexer; unpopulated channel slots read as zero.
    always_comb begin
        rdData = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(chanIdx) == i) begin
                case (regSel)
                    2'd0: rdData = count_q[i];
`ifdef RIOT_TIMER_CASCADE_EN
                    2'd1: rdData = TIMER_W'({cas_q[i], ar_q[i], ie_q[i], sel_q[i]});
`else
                    2'd1: rdData = TIMER_W'({ar_q[i], ie_q[i], sel_q[i]});
`endif
                    2'd2: rdData = reload_q[i];
                    default: rdData = TIMER_W'({run_q[i], exp_q[i], flag_q[i]});
                endcase
            end
        end
    end

    // State registers and registered read data.
    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= '0;
                reload_q[i] <= '0;
                ps_q[i]     <= '0;
                sel_q[i]    <= '0;
            end
            ie_q   <= '0;
            ar_q   <= '0;
            flag_q <= '0;
            exp_q  <= '0;
            run_q  <= '0;
`ifdef RIOT_TIMER_CASCADE_EN
            cas_q  <= '0;
`endif
            dout_q <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
                ps_q[i]     <= ps_d[i];
                sel_q[i]    <= sel_d[i];
            end
            ie_q   <= ie_d;
            ar_q   <= ar_d;
            flag_q <= flag_d;
            exp_q  <= exp_d;
            run_q  <= run_d;
`ifdef RIOT_TIMER_CASCADE_EN
            cas_q  <= cas_d;
`endif
            if (rdEn) begin
                dout_q <= rdData;
            end
        end
    end

    assign Dout  = dout_q;
    assign IRQ_n = ~|(flag_q & ie_q);

endmodule
